tinyml_display_vga_timing_rx: RTL and testbench

//  Receive-side counterpart of the display sync generator. Samples a DE/HS/VS video stream in the pixel clock domain.

---
 rtl/tinyml_display_vga_timing_rx.sv | 171 +++++++++++++++++
 tb/tb_tinyml_display_vga_timing_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tinyml_display_vga_timing_rx.sv
// Recovers pixel coordinates and line/frame timing from a DE/HS(low)/VS(low) stream; locks after LOCK_FRAMES stable frames.
// Coordinates lag in_de by 2 cycles; no backpressure, the video stream is free-running.
module tinyml_display_vga_timing_rx #(
  parameter int PW          = 14,
  parameter int VW          = 12,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT_W   = 16
) (
  input  logic          in_pclk,
  input  logic          in_rst,
  input  logic          in_de,
  input  logic          in_hs,
  input  logic          in_vs,
  output logic [PW-1:0] out_x,
  output logic [VW-1:0] out_y,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eol,
  output logic [PW-1:0] out_h_total,
  output logic [PW-1:0] out_h_active,
  output logic [VW-1:0] out_v_total,
  output logic [VW-1:0] out_v_active,
  output logic          out_locked,
  output logic          out_err
);
  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, CHECK = 2'd2, LOCKED = 2'd3} state_t;

  state_t               state_q, state_d;
  logic                 de_s1_q, hs_s1_q, vs_s1_q, de_s2_q, hs_s2_q, vs_s2_q;
  logic [PW-1:0]        x_q, x_d;
  logic [VW-1:0]        y_q, y_d;
  logic                 valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic [PW-1:0]        h_cnt_q, h_cnt_d, h_line_q, h_line_d, run_q, run_d, ha_line_q, ha_line_d;
  logic [VW-1:0]        vh_cnt_q, vh_cnt_d, vd_cnt_q, vd_cnt_d;
  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
  logic [PW-1:0]        ref_ht_q, ref_ht_d, ref_ha_q, ref_ha_d, m_ht_q, m_ht_d, m_ha_q, m_ha_d;
  logic [VW-1:0]        ref_vt_q, ref_vt_d, ref_va_q, ref_va_d, m_vt_q, m_vt_d, m_va_q, m_va_d;
  logic [3:0]           match_q, match_d;
  logic                 locked_q, locked_d, err_q, err_d;

  logic                 de_rise, de_fall, hs_fall, vs_fall, timeout, sat_err, chk_err, frame_match;
  logic [PW-1:0]        h_inc, run_inc, fr_ht, fr_ha;
  logic [VW-1:0]        vh_inc, vd_inc, fr_vt, fr_va;

  assign de_rise = de_s1_q & ~de_s2_q;
  assign de_fall = ~de_s1_q & de_s2_q;
  assign hs_fall = ~hs_s1_q & hs_s2_q;
  assign vs_fall = ~vs_s1_q & vs_s2_q;

  // Saturating increments; counters stick at all-ones rather than wrapping.
  assign h_inc   = (&h_cnt_q)  ? h_cnt_q  : h_cnt_q + 1'b1;
  assign run_inc = (&run_q)    ? run_q    : run_q + 1'b1;
  assign vh_inc  = (&vh_cnt_q) ? vh_cnt_q : vh_cnt_q + 1'b1;
  assign vd_inc  = (&vd_cnt_q) ? vd_cnt_q : vd_cnt_q + 1'b1;

  // An edge coinciding with VS fall still belongs to the frame that is ending.
  assign fr_ht = hs_fall ? h_cnt_q : h_line_q;
  assign fr_ha = de_fall ? run_q   : ha_line_q;
  assign fr_vt = hs_fall ? vh_inc  : vh_cnt_q;
  assign fr_va = de_fall ? vd_inc  : vd_cnt_q;
  assign frame_match = (fr_ht == ref_ht_q) && (fr_ha == ref_ha_q) &&
                       (fr_vt == ref_vt_q) && (fr_va == ref_va_q);

  always_comb begin
    x_d       = de_s1_q ? (de_s2_q ? x_q + 1'b1 : '0) : '0;
    y_d       = vs_fall ? '0 : (de_fall ? y_q + 1'b1 : y_q);
    valid_d   = de_s1_q;
    sof_d     = de_s1_q && (x_d == '0) && (y_d == '0);
    eol_d     = de_s1_q && !in_de;
    h_cnt_d   = hs_fall ? PW'(1) : h_inc;
    h_line_d  = hs_fall ? h_cnt_q : h_line_q;
    run_d     = de_s1_q ? (de_rise ? PW'(1) : run_inc) : run_q;
    ha_line_d = de_fall ? run_q : ha_line_q;
    vh_cnt_d  = vs_fall ? '0 : fr_vt;
    vd_cnt_d  = vs_fall ? '0 : fr_va;
    to_cnt_d  = hs_fall ? '0 : to_cnt_q + 1'b1;
    timeout   = &to_cnt_d;
    if (timeout) to_cnt_d = '0;
    sat_err   = (!hs_fall && (&h_inc) && !(&h_cnt_q)) ||
                (de_s1_q && !de_rise && (&run_inc) && !(&run_q)) ||
                (hs_fall && (&vh_inc) && !(&vh_cnt_q)) ||
                (de_fall && (&vd_inc) && !(&vd_cnt_q));
  end

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    ref_ht_d = ref_ht_q;
    ref_ha_d = ref_ha_q;
    ref_vt_d = ref_vt_q;
    ref_va_d = ref_va_q;
    m_ht_d   = m_ht_q;
    m_ha_d   = m_ha_q;
    m_vt_d   = m_vt_q;
    m_va_d   = m_va_q;
    chk_err  = 1'b0;
    if (timeout) begin
      state_d = SEARCH;
      match_d = '0;
    end else if (vs_fall) begin
      case (state_q)
        SEARCH:  state_d = MEASURE;
        MEASURE: begin
          {ref_ht_d, ref_ha_d, ref_vt_d, ref_va_d} = {fr_ht, fr_ha, fr_vt, fr_va};
          match_d = 4'd1;
          state_d = (LOCK_FRAMES <= 1) ? LOCKED : CHECK;
        end
        CHECK: begin
          if (frame_match) begin
            match_d = match_q + 4'd1;
            if (match_d >= 4'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            {ref_ht_d, ref_ha_d, ref_vt_d, ref_va_d} = {fr_ht, fr_ha, fr_vt, fr_va};
            match_d = 4'd1;
            chk_err = 1'b1;
          end
        end
        default: begin
          if (!frame_match) begin
            {ref_ht_d, ref_ha_d, ref_vt_d, ref_va_d} = {fr_ht, fr_ha, fr_vt, fr_va};
            match_d = 4'd1;
            chk_err = 1'b1;
            state_d = CHECK;
          end
        end
      endcase
      // Published timing only moves when a frame is accepted as locked.
      if (state_d == LOCKED) {m_ht_d, m_ha_d, m_vt_d, m_va_d} = {fr_ht, fr_ha, fr_vt, fr_va};
    end
    locked_d = (state_d == LOCKED);
    err_d    = timeout | sat_err | chk_err;
  end

  always_ff @(posedge in_pclk) begin
    if (in_rst) begin
      state_q  <= SEARCH;
      de_s1_q  <= 1'b0;  hs_s1_q <= 1'b1;  vs_s1_q <= 1'b1;
      de_s2_q  <= 1'b0;  hs_s2_q <= 1'b1;  vs_s2_q <= 1'b1;
      x_q      <= '0;    y_q     <= '0;
      valid_q  <= 1'b0;  sof_q   <= 1'b0;  eol_q   <= 1'b0;
      h_cnt_q  <= '0;    h_line_q <= '0;   run_q   <= '0;   ha_line_q <= '0;
      vh_cnt_q <= '0;    vd_cnt_q <= '0;   to_cnt_q <= '0;
      ref_ht_q <= '0;    ref_ha_q <= '0;   ref_vt_q <= '0;  ref_va_q  <= '0;
      m_ht_q   <= '0;    m_ha_q   <= '0;   m_vt_q   <= '0;  m_va_q    <= '0;
      match_q  <= '0;    locked_q <= 1'b0; err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      de_s1_q  <= in_de;    hs_s1_q <= in_hs;    vs_s1_q <= in_vs;
      de_s2_q  <= de_s1_q;  hs_s2_q <= hs_s1_q;  vs_s2_q <= vs_s1_q;
      x_q      <= x_d;      y_q     <= y_d;
      valid_q  <= valid_d;  sof_q   <= sof_d;    eol_q   <= eol_d;
      h_cnt_q  <= h_cnt_d;  h_line_q <= h_line_d; run_q  <= run_d;  ha_line_q <= ha_line_d;
      vh_cnt_q <= vh_cnt_d; vd_cnt_q <= vd_cnt_d; to_cnt_q <= to_cnt_d;
      ref_ht_q <= ref_ht_d; ref_ha_q <= ref_ha_d; ref_vt_q <= ref_vt_d; ref_va_q <= ref_va_d;
      m_ht_q   <= m_ht_d;   m_ha_q   <= m_ha_d;   m_vt_q   <= m_vt_d;   m_va_q   <= m_va_d;
      match_q  <= match_d;  locked_q <= locked_d; err_q    <= err_d;
    end
  end

  assign out_x        = x_q;
  assign out_y        = y_q;
  assign out_valid    = valid_q;
  assign out_sof      = sof_q;
  assign out_eol      = eol_q;
  assign out_h_total  = m_ht_q;
  assign out_h_active = m_ha_q;
  assign out_v_total  = m_vt_q;
  assign out_v_active = m_va_q;
  assign out_locked   = locked_q;
  assign out_err      = err_q;
endmodule

// File: tb/tb_tinyml_display_vga_timing_rx.sv
// Bench for tinyml_display_vga_timing_rx: scaled-down video modes, pixel scoreboard, lock/err scenarios.
module tb_tinyml_display_vga_timing_rx;
  localparam int PW = 14;
  localparam int VW = 12;
  localparam int TW = 8;
  localparam int VT = 10, VSW = 2, VS0 = 3, VA = 6;

  logic          core_clk = 1'b0;
  logic          rst, de, hs, vs;
  logic [PW-1:0] out_x, out_h_total, out_h_active;
  logic [VW-1:0] out_y, out_v_total, out_v_active;
  logic          out_valid, out_sof, out_eol, out_locked, out_err;

  typedef struct packed {
    logic [PW-1:0] x;
    logic [VW-1:0] y;
    logic          sof;
    logic          eol;
  } pix_t;

  pix_t sb_q[$];
  int   checks = 0, failures = 0;
  int   err_cnt = 0, sof_cnt = 0, eol_cnt = 0, pix_cnt = 0;
  bit   sb_en = 1'b1;

  always #5 core_clk = ~core_clk;

  tinyml_display_vga_timing_rx #(.PW(PW), .VW(VW), .LOCK_FRAMES(2), .TIMEOUT_W(TW)) dut (
    .in_pclk(core_clk), .in_rst(rst), .in_de(de), .in_hs(hs), .in_vs(vs),
    .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
    .out_h_total(out_h_total), .out_h_active(out_h_active),
    .out_v_total(out_v_total), .out_v_active(out_v_active),
    .out_locked(out_locked), .out_err(out_err)
  );

  // Pixel scoreboard and event counters, sampled mid-cycle.
  always @(negedge core_clk) begin
    pix_t e;
    if (out_err) err_cnt++;
    if (out_sof) sof_cnt++;
    if (out_eol) eol_cnt++;
    if (out_valid && sb_en) begin
      pix_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_pixel got x=%0d y=%0d, expected no pixel", out_x, out_y);
      end else begin
        e = sb_q.pop_front();
        if ({out_x, out_y, out_sof, out_eol} !== e) begin
          failures++;
          $display("FAIL sb_pixel got x=%0d y=%0d sof=%0b eol=%0b, expected x=%0d y=%0d sof=%0b eol=%0b",
                   out_x, out_y, out_sof, out_eol, e.x, e.y, e.sof, e.eol);
        end
      end
    end
  end

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic drive_line(input int ht, input int hsw, input int hs0, input int ha, input int line);
    pix_t p;
    for (int c = 0; c < ht; c++) begin
      hs = (c < hsw) ? 1'b0 : 1'b1;
      vs = (line < VSW) ? 1'b0 : 1'b1;
      de = (line >= VS0) && (line < VS0 + VA) && (c >= hs0) && (c < hs0 + ha);
      if (de && sb_en) begin
        p.x   = PW'(c - hs0);
        p.y   = VW'(line - VS0);
        p.sof = (c == hs0) && (line == VS0);
        p.eol = (c == hs0 + ha - 1);
        sb_q.push_back(p);
      end
      tick();
    end
  endtask

  task automatic drive_frame(input int ht, input int ha);
    for (int l = 0; l < VT; l++) drive_line(ht, 3, 5, ha, l);
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; de = 1'b0; hs = 1'b1; vs = 1'b1;
    repeat (3) tick();
    checks++;
    if ({out_x, out_y, out_valid, out_sof, out_eol} !== '0) begin
      failures++;
      $display("FAIL reset_coord got x=%0d y=%0d v=%0b, expected all 0", out_x, out_y, out_valid);
    end
    checks++;
    if ({out_h_total, out_h_active, out_v_total, out_v_active} !== '0) begin
      failures++;
      $display("FAIL reset_meas got %0d/%0d/%0d/%0d, expected all 0", out_h_total, out_h_active, out_v_total, out_v_active);
    end
    checks++;
    if ({out_locked, out_err} !== 2'b00) begin
      failures++;
      $display("FAIL reset_status got locked=%0b err=%0b, expected 0 0", out_locked, out_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lock();
    int e0 = err_cnt;
    drive_frame(20, 12);
    drive_frame(20, 12);
    expect_int("lock_not_before_3rd_vs", out_locked, 0);
    drive_frame(20, 12);
    expect_int("lock_after_3rd_vs", out_locked, 1);
    expect_int("lock_h_total", out_h_total, 20);
    expect_int("lock_h_active", out_h_active, 12);
    expect_int("lock_v_total", out_v_total, 10);
    expect_int("lock_v_active", out_v_active, 6);
    expect_int("lock_no_err", err_cnt - e0, 0);
  endtask

  task automatic test_stream();
    int s0 = sof_cnt, l0 = eol_cnt, p0 = pix_cnt;
    drive_frame(20, 12);
    expect_int("stream_sof_per_frame", sof_cnt - s0, 1);
    expect_int("stream_eol_per_frame", eol_cnt - l0, VA);
    expect_int("stream_pixels_per_frame", pix_cnt - p0, 12 * VA);
    expect_int("stream_sb_drained", sb_q.size(), 0);
    expect_int("stream_still_locked", out_locked, 1);
  endtask

  task automatic test_mode_switch();
    int e0 = err_cnt;
    drive_frame(33, 24);
    expect_int("switch_old_frame_ok", out_locked, 1);
    expect_int("switch_no_err_yet", err_cnt - e0, 0);
    drive_frame(33, 24);
    expect_int("switch_unlocked", out_locked, 0);
    expect_int("switch_err_pulse", err_cnt - e0, 1);
    expect_int("switch_meas_held", out_h_total, 20);
    drive_frame(33, 24);
    expect_int("switch_relocked", out_locked, 1);
    expect_int("switch_h_total", out_h_total, 33);
    expect_int("switch_h_active", out_h_active, 24);
    expect_int("switch_v_total", out_v_total, 10);
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    de = 1'b0; hs = 1'b1; vs = 1'b1;
    repeat (300) tick();
    expect_int("timeout_err_pulse", err_cnt - e0, 1);
    expect_int("timeout_unlocked", out_locked, 0);
    expect_int("timeout_meas_held", out_h_total, 33);
    drive_frame(20, 12);
    drive_frame(20, 12);
    expect_int("timeout_search_no_early_lock", out_locked, 0);
    drive_frame(20, 12);
    expect_int("timeout_relocked", out_locked, 1);
    expect_int("timeout_relock_h_total", out_h_total, 20);
    expect_int("timeout_no_extra_err", err_cnt - e0, 1);
  endtask

  task automatic test_mid_reset();
    for (int l = 0; l < 5; l++) drive_line(20, 3, 5, 12, l);
    sb_en = 1'b0;
    rst = 1'b1; de = 1'b0; hs = 1'b1; vs = 1'b1;
    tick();
    checks++;
    if ({out_x, out_y, out_valid, out_sof, out_eol, out_locked, out_err} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got x=%0d y=%0d v=%0b locked=%0b, expected all 0", out_x, out_y, out_valid, out_locked);
    end
    checks++;
    if ({out_h_total, out_h_active, out_v_total, out_v_active} !== '0) begin
      failures++;
      $display("FAIL midreset_meas got %0d/%0d/%0d/%0d, expected all 0", out_h_total, out_h_active, out_v_total, out_v_active);
    end
    rst = 1'b0;
    sb_q.delete();
    for (int l = 5; l < VT; l++) drive_line(20, 3, 5, 12, l);
    sb_en = 1'b1;
    drive_frame(20, 12);
    drive_frame(20, 12);
    expect_int("midreset_no_early_lock", out_locked, 0);
    drive_frame(20, 12);
    expect_int("midreset_relocked", out_locked, 1);
    expect_int("midreset_h_active", out_h_active, 12);
  endtask

  task automatic test_one_pixel();
    int e0, s0, l0;
    e0 = err_cnt;
    drive_frame(20, 1);
    drive_frame(20, 1);
    expect_int("onepix_unlock_err", err_cnt - e0, 1);
    s0 = sof_cnt; l0 = eol_cnt;
    drive_frame(20, 1);
    expect_int("onepix_locked", out_locked, 1);
    expect_int("onepix_h_active", out_h_active, 1);
    expect_int("onepix_h_total", out_h_total, 20);
    expect_int("onepix_v_total", out_v_total, 10);
    expect_int("onepix_v_active", out_v_active, 6);
    expect_int("onepix_eol_count", eol_cnt - l0, VA);
    expect_int("onepix_sof_count", sof_cnt - s0, 1);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_stream();
    test_mode_switch();
    test_timeout();
    test_mid_reset();
    test_one_pixel();
    repeat (4) tick();
    expect_int("final_sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
